// File: rtl/pico_cmd_rx.sv
// Serial command receiver: deserialises LSB-first address/data bytes on sclk,
// drives the POCI readout mux select and owns the writable config registers.
module pico_cmd_rx #(
    parameter int         NUM_REGS  = 59,
    parameter int         NUM_WR    = 3,
    parameter logic [7:0] MASK_RST  = 8'h00,
    parameter logic [7:0] INSTR_RST = 8'h00,
    parameter logic [7:0] MODE_RST  = 8'h00
) (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       csn,
    input  logic       serial_in,
    output logic [7:0] control_signal,
    output logic [7:0] trigger_channel_mask,
    output logic [7:0] instruction,
    output logic [7:0] mode,
    output logic       write_strobe,
    output logic       addr_error
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        WDATA,
        DISCARD
    } state_t;

    localparam logic [6:0] MAX_ADDR = 7'(NUM_REGS);
    localparam logic [6:0] MAX_WR   = 7'(NUM_WR);

    state_t     state, state_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] ctrl_next, mask_next, instr_next, mode_next;
    logic       strobe_next, err_next;

    logic [7:0] shifted;
    logic [6:0] addr;
    logic       byte_done;

    // New bits enter at the MSB so the first bit received ends up as bit0.
    assign shifted   = {serial_in, shift_reg[7:1]};
    assign addr      = shifted[6:0];
    assign byte_done = (bit_cnt == 3'd7);

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            state                <= IDLE;
            bit_cnt              <= 3'd0;
            shift_reg            <= 8'h00;
            control_signal       <= 8'h00;
            trigger_channel_mask <= MASK_RST;
            instruction          <= INSTR_RST;
            mode                 <= MODE_RST;
            write_strobe         <= 1'b0;
            addr_error           <= 1'b0;
        end else begin
            state                <= state_next;
            bit_cnt              <= bit_cnt_next;
            shift_reg            <= shift_next;
            control_signal       <= ctrl_next;
            trigger_channel_mask <= mask_next;
            instruction          <= instr_next;
            mode                 <= mode_next;
            write_strobe         <= strobe_next;
            addr_error           <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt + 3'd1;
        shift_next   = shifted;
        ctrl_next    = control_signal;
        mask_next    = trigger_channel_mask;
        instr_next   = instruction;
        mode_next    = mode;
        strobe_next  = 1'b0;
        err_next     = addr_error;

        if (csn) begin
            state_next   = IDLE;
            bit_cnt_next = 3'd0;
            shift_next   = 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_next = 3'd1;
                    err_next     = 1'b0;
                    state_next   = ADDR;
                end
                ADDR: begin
                    if (byte_done) begin
                        // Out-of-range addresses map to 0 so the mux never sees an invalid select.
                        ctrl_next = (addr <= MAX_ADDR) ? {1'b0, addr} : 8'h00;
                        if (!shifted[7]) begin
                            err_next   = (addr > MAX_ADDR) ? 1'b1 : addr_error;
                            state_next = READ;
                        end else if (addr >= 7'd1 && addr <= MAX_WR) begin
                            state_next = WDATA;
                        end else begin
                            err_next   = 1'b1;
                            state_next = DISCARD;
                        end
                    end
                end
                READ: begin
                    shift_next = shift_reg;
                    if (byte_done) state_next = ADDR;
                end
                WDATA: begin
                    if (byte_done) begin
                        // control_signal still holds the validated write target here.
                        case (control_signal)
                            8'd1:    mask_next  = shifted;
                            8'd2:    instr_next = shifted;
                            8'd3:    mode_next  = shifted;
                            default: ;
                        endcase
                        strobe_next = 1'b1;
                        state_next  = ADDR;
                    end
                end
                DISCARD: begin
                    if (byte_done) state_next = ADDR;
                end
                default: begin
                    state_next   = IDLE;
                    bit_cnt_next = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pico_cmd_rx.sv
// Directed self-checking bench for pico_cmd_rx: reads, writes, address errors,
// frame aborts, mid-write reset and back-to-back transactions in one frame.
module tb_pico_cmd_rx;

    logic       sclk;
    logic       rstn;
    logic       csn;
    logic       serial_in;
    logic [7:0] control_signal;
    logic [7:0] trigger_channel_mask;
    logic [7:0] instruction;
    logic [7:0] mode;
    logic       write_strobe;
    logic       addr_error;

    int compared   = 0;
    int mismatched = 0;

    pico_cmd_rx dut (
        .sclk                 (sclk),
        .rstn                 (rstn),
        .csn                  (csn),
        .serial_in            (serial_in),
        .control_signal       (control_signal),
        .trigger_channel_mask (trigger_channel_mask),
        .instruction          (instruction),
        .mode                 (mode),
        .write_strobe         (write_strobe),
        .addr_error           (addr_error)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] value, input int count);
        for (int i = 0; i < count; i++) begin
            csn       = 1'b0;
            serial_in = value[i];
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] value);
        send_bits(value, 8);
    endtask

    task automatic end_frame();
        csn       = 1'b1;
        serial_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        csn  = 1'b1;
        tick();
        tick();
        compared++;
        if (control_signal !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %0d expected 0", control_signal);
        end
        compared++;
        if (trigger_channel_mask !== 8'h00 || instruction !== 8'h00 || mode !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_regs: got %h/%h/%h expected 00/00/00",
                     trigger_channel_mask, instruction, mode);
        end
        compared++;
        if (write_strobe !== 1'b0 || addr_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got strobe=%b err=%b expected 0/0", write_strobe, addr_error);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_read();
        send_byte(8'h05);
        compared++;
        if (control_signal !== 8'd5) begin
            mismatched++;
            $display("[TB] FAIL read_ctrl: got %0d expected 5", control_signal);
        end
        for (int i = 0; i < 8; i++) begin
            csn       = 1'b0;
            serial_in = 1'b1;
            tick();
            compared++;
            if (control_signal !== 8'd5 || write_strobe !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL read_hold[%0d]: got ctrl=%0d strobe=%b expected 5/0",
                         i, control_signal, write_strobe);
            end
        end
        end_frame();
    endtask

    task automatic test_read_bounds();
        logic [7:0] addr_vec [3]  = '{8'h00, 8'h3B, 8'h3C};
        logic [7:0] ctrl_exp [3]  = '{8'd0, 8'd59, 8'd0};
        logic       err_exp  [3]  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            send_byte(addr_vec[i]);
            compared++;
            if (control_signal !== ctrl_exp[i] || addr_error !== err_exp[i]) begin
                mismatched++;
                $display("[TB] FAIL read_bound_%h: got ctrl=%0d err=%b expected %0d/%b",
                         addr_vec[i], control_signal, addr_error, ctrl_exp[i], err_exp[i]);
            end
            end_frame();
        end
    endtask

    task automatic test_write();
        send_byte(8'h82);
        send_byte(8'hA5);
        compared++;
        if (instruction !== 8'hA5 || write_strobe !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL write_commit: got instr=%h strobe=%b expected a5/1", instruction, write_strobe);
        end
        compared++;
        if (trigger_channel_mask !== 8'h00 || mode !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL write_others: got mask=%h mode=%h expected 00/00", trigger_channel_mask, mode);
        end
        end_frame();
        compared++;
        if (write_strobe !== 1'b0 || instruction !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL write_strobe_len: got strobe=%b instr=%h expected 0/a5", write_strobe, instruction);
        end
    endtask

    task automatic test_errors();
        send_byte(8'h3F);
        compared++;
        if (control_signal !== 8'd0 || addr_error !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_read63: got ctrl=%0d err=%b expected 0/1", control_signal, addr_error);
        end
        end_frame();
        compared++;
        if (addr_error !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_retained: got %b expected 1", addr_error);
        end
        send_bits(8'h85, 1);
        compared++;
        if (addr_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_clear_on_frame: got %b expected 0", addr_error);
        end
        send_bits(8'h85 >> 1, 7);
        compared++;
        if (addr_error !== 1'b1 || control_signal !== 8'd5) begin
            mismatched++;
            $display("[TB] FAIL err_write5: got err=%b ctrl=%0d expected 1/5", addr_error, control_signal);
        end
        send_byte(8'hFF);
        compared++;
        if (trigger_channel_mask !== 8'h00 || instruction !== 8'hA5 || mode !== 8'h00 || write_strobe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_discard: got %h/%h/%h strobe=%b expected 00/a5/00 0",
                     trigger_channel_mask, instruction, mode, write_strobe);
        end
        send_byte(8'h80);
        compared++;
        if (addr_error !== 1'b1 || control_signal !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL err_write0: got err=%b ctrl=%0d expected 1/0", addr_error, control_signal);
        end
        end_frame();
        send_byte(8'h01);
        compared++;
        if (addr_error !== 1'b0 || control_signal !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL err_new_frame: got err=%b ctrl=%0d expected 0/1", addr_error, control_signal);
        end
        end_frame();
    endtask

    task automatic test_abort();
        send_byte(8'h83);
        send_bits(8'h0F, 4);
        end_frame();
        compared++;
        if (mode !== 8'h00 || write_strobe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_no_write: got mode=%h strobe=%b expected 00/0", mode, write_strobe);
        end
        tick();
        compared++;
        if (write_strobe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_no_strobe: got %b expected 0", write_strobe);
        end
        send_byte(8'h83);
        send_byte(8'h3C);
        compared++;
        if (mode !== 8'h3C || write_strobe !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort_recover: got mode=%h strobe=%b expected 3c/1", mode, write_strobe);
        end
        end_frame();
    endtask

    task automatic test_mid_reset();
        send_byte(8'h81);
        send_bits(8'hFF, 4);
        rstn = 1'b0;
        csn  = 1'b1;
        tick();
        compared++;
        if (trigger_channel_mask !== 8'h00 || instruction !== 8'h00 || mode !== 8'h00 ||
            control_signal !== 8'h00 || write_strobe !== 1'b0 || addr_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got %h/%h/%h ctrl=%0d strobe=%b err=%b expected all 0",
                     trigger_channel_mask, instruction, mode, control_signal, write_strobe, addr_error);
        end
        rstn = 1'b1;
        tick();
        compared++;
        if (write_strobe !== 1'b0 || trigger_channel_mask !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_after: got strobe=%b mask=%h expected 0/00", write_strobe, trigger_channel_mask);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h81);
        send_byte(8'h0F);
        compared++;
        if (trigger_channel_mask !== 8'h0F || write_strobe !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_write: got mask=%h strobe=%b expected 0f/1", trigger_channel_mask, write_strobe);
        end
        send_byte(8'h01);
        compared++;
        if (control_signal !== 8'd1 || write_strobe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_read1: got ctrl=%0d strobe=%b expected 1/0", control_signal, write_strobe);
        end
        send_byte(8'h00);
        send_byte(8'h3B);
        compared++;
        if (control_signal !== 8'd59 || addr_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_read59: got ctrl=%0d err=%b expected 59/0", control_signal, addr_error);
        end
        end_frame();
    endtask

    initial begin
        rstn      = 1'b0;
        csn       = 1'b1;
        serial_in = 1'b0;
        test_reset();
        test_read();
        test_read_bounds();
        test_write();
        test_errors();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
